pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the following ports; one clock, reset asynchronous and active-high:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- irq  in  8  level interrupt requests
- if_busy  in  1  fetch bus wait
- mem_busy  in  1  data bus wait
- ld_hazard  in  1  load-use hazard from decode
- mem_en  in  1  MEM stage valid
- mem_pc  in  30  word PC at MEM, already +1
- mem_ctrl_op  in  2  NOP/WRCR/EXRT
- mem_exp_code  in  3  exception code, 0 = none
- mem_dst_addr  in  5  creg index for WRCR
- mem_out  in  32  WRCR data
- creg_rd_addr  in  5  creg read index
- creg_rd_data  out  32  creg read data, combinational
- exe_mode  out  1  0 = kernel, 1 = user
- stall  out  4  {mem,ex,id,if}
- flush  out  4  {mem,ex,id,if}
- new_pc  out  30  redirect target, valid when flush[0]

Function
REQ-002 SHALL implement these control registers; unlisted indices read 0 and ignore writes:
- 0 STATUS {int_en[1], exe_mode[0]}
- 1 PRE_STATUS
- 2 EPC[31:2]
- 3 EXP_VECTOR[31:2]
- 4 CAUSE[2:0]
- 5 INT_MASK[7:0], 1 = masked
- 6 IRQ_PEND[7:0], write-1-to-clear
REQ-003 SHALL set IRQ_PEND bit n on every clk where irq[n]=1; set SHALL win over a same-cycle clear.
REQ-004 int_req SHALL equal int_en & |(IRQ_PEND & ~INT_MASK) & mem_en & (state==RUN).
REQ-005 If if_busy|mem_busy, stall SHALL be 4'b1111, flush 0, and there SHALL be no state or creg update except IRQ_PEND sampling.
REQ-006 Otherwise, exception (mem_en & mem_exp_code!=0) SHALL take priority:
- flush=4'b1111, new_pc=EXP_VECTOR
- next edge: PRE_STATUS<=STATUS, STATUS<={0,kernel}, EPC<=mem_pc-1, CAUSE<=mem_exp_code.
REQ-007 Else int_req SHALL behave as REQ-006 with CAUSE<=3'd0 (interrupt).
REQ-008 Else EXRT (mem_en) SHALL give flush=4'b1111, new_pc=EPC, and STATUS<=PRE_STATUS at the next edge.
REQ-009 Else WRCR (mem_en) SHALL write creg[mem_dst_addr]<=mem_out at the next edge, with flush=4'b1111 and new_pc=mem_pc.
REQ-010 Else ld_hazard SHALL give stall=4'b0011 and flush=4'b0100 (bubble into EX).
REQ-011 Else stall=0 and flush=0.
REQ-012 The FSM SHALL have states RUN and DRAIN:
- any redirect of REQ-006..009 moves RUN->DRAIN
- DRAIN->RUN unconditionally after one unstalled cycle
- in DRAIN, interrupts SHALL NOT be accepted; exceptions SHALL still be honoured.
REQ-013 A WRCR or EXRT coinciding with an accepted exception/interrupt SHALL be discarded; EPC points to it for re-execution.
REQ-014 mem_pc-1 SHALL wrap modulo 2^30.
REQ-015 creg_rd_data SHALL reflect register contents before any same-cycle write; no bypass.
REQ-016 exe_mode SHALL equal STATUS[0].

Reset
REQ-017 On reset, all outputs SHALL be held at their reset values asynchronously:
- STATUS=PRE_STATUS=2'b00 (kernel, int disabled)
- EPC=0, EXP_VECTOR=0, CAUSE=0
- INT_MASK=8'hFF, IRQ_PEND=0
- state=RUN, stall=0, flush=0, new_pc=0
REQ-018 Reset deassertion mid-operation SHALL resume in RUN with no pending redirect.

Structure
REQ-019 Creg indices, exception codes, ctrl_op encodings and exe_mode values SHALL live in the shared CPU package; the module SHALL hold no local literals.
REQ-020 The control register file with IRQ_PEND latching SHALL be a sub-module pipe_ctrl_creg; priority logic and FSM SHALL stay in pipe_ctrl.

Verification
REQ-021 The bench SHALL cover:
- EXP_VECTOR=0x100 (word), mem_exp_code=TRAP, mem_pc=0x21 -> flush=1111, new_pc=0x100; next cycle EPC=0x20, CAUSE=TRAP, STATUS=2'b00.
- INT_MASK=0xFE, int_en=1, irq[0] pulsed one cycle, mem_en=1 -> interrupt taken, CAUSE=0; write IRQ_PEND=0x01 clears it.
- EXRT with EPC=0x40, PRE_STATUS=2'b11 -> new_pc=0x40; next cycle exe_mode=1, int_en=1.
- ld_hazard=1 with mem_busy=1 -> stall=1111, flush=0; mem_busy drops -> stall=0011, flush=0100.
- WRCR STATUS=2'b01 at MEM plus pending unmasked irq -> interrupt wins; STATUS unchanged; EPC=mem_pc-1.
- Reset asserted in DRAIN -> all outputs at reset values immediately; post-reset interrupt accepted on the first eligible cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller:
// creg indices, exception codes, ctrl ops, modes and stall/flush vectors.
package pipe_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int PCW  = 30;
  localparam int NIRQ = 8;
  localparam int CRAW = 5;

  typedef logic [CRAW-1:0] creg_addr_t;
  typedef logic [2:0]      exp_code_t;
  typedef logic [1:0]      ctrl_op_t;
  typedef logic [3:0]      pipe_vec_t;

  localparam creg_addr_t CR_STATUS     = 5'd0;
  localparam creg_addr_t CR_PRE_STATUS = 5'd1;
  localparam creg_addr_t CR_EPC        = 5'd2;
  localparam creg_addr_t CR_EXP_VECTOR = 5'd3;
  localparam creg_addr_t CR_CAUSE      = 5'd4;
  localparam creg_addr_t CR_INT_MASK   = 5'd5;
  localparam creg_addr_t CR_IRQ_PEND   = 5'd6;

  localparam exp_code_t EXP_NONE    = 3'd0;
  localparam exp_code_t EXP_INT     = 3'd0;
  localparam exp_code_t EXP_ILLEGAL = 3'd1;
  localparam exp_code_t EXP_TRAP    = 3'd2;
  localparam exp_code_t EXP_OVF     = 3'd3;
  localparam exp_code_t EXP_PRIV    = 3'd4;

  localparam ctrl_op_t CTRL_NOP  = 2'd0;
  localparam ctrl_op_t CTRL_WRCR = 2'd1;
  localparam ctrl_op_t CTRL_EXRT = 2'd2;

  localparam logic MODE_KERNEL = 1'b0;
  localparam logic MODE_USER   = 1'b1;

  localparam pipe_vec_t VEC_NONE   = 4'b0000;
  localparam pipe_vec_t VEC_ALL    = 4'b1111;
  localparam pipe_vec_t STALL_LOAD = 4'b0011;
  localparam pipe_vec_t FLUSH_BUBL = 4'b0100;

  localparam logic [NIRQ-1:0] INT_MASK_RST = 8'hFF;

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  typedef struct packed {
    logic int_en;
    logic mode;
  } status_t;

  localparam status_t STATUS_RST  = '{int_en: 1'b0, mode: MODE_KERNEL};
  localparam status_t STATUS_TRAP = '{int_en: 1'b0, mode: MODE_KERNEL};

  function automatic logic [PCW-1:0] pc_prev(input logic [PCW-1:0] pc);
    return pc - PCW'(1);
  endfunction

  function automatic logic [XLEN-1:0] word2byte(input logic [PCW-1:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control register file; IRQ_PEND latches every cycle, set beats W1C.
// Trap entry/return and WRCR writes are gated by the controller.
module pipe_ctrl_creg
  import pipe_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NIRQ-1:0]  i_irq,
  input  logic             i_we,
  input  creg_addr_t       i_wr_addr,
  input  logic [XLEN-1:0]  i_wr_data,
  input  logic             i_trap_we,
  input  logic [PCW-1:0]   i_trap_epc,
  input  exp_code_t        i_trap_cause,
  input  logic             i_exrt_we,
  input  creg_addr_t       i_rd_addr,
  output logic [XLEN-1:0]  o_rd_data,
  output status_t          o_status,
  output logic [PCW-1:0]   o_epc,
  output logic [PCW-1:0]   o_exp_vector,
  output logic [NIRQ-1:0]  o_irq_pend,
  output logic [NIRQ-1:0]  o_int_mask
);

  status_t          r_status;
  status_t          r_pre_status;
  logic [PCW-1:0]   r_epc;
  logic [PCW-1:0]   r_exp_vector;
  exp_code_t        r_cause;
  logic [NIRQ-1:0]  r_int_mask;
  logic [NIRQ-1:0]  r_irq_pend;
  logic [NIRQ-1:0]  w_pend_clr;

  assign w_pend_clr = (i_we && i_wr_addr == CR_IRQ_PEND)
                    ? i_wr_data[NIRQ-1:0] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_status     <= STATUS_RST;
      r_pre_status <= STATUS_RST;
      r_epc        <= '0;
      r_exp_vector <= '0;
      r_cause      <= EXP_NONE;
      r_int_mask   <= INT_MASK_RST;
      r_irq_pend   <= '0;
    end else begin
      r_irq_pend <= (r_irq_pend & ~w_pend_clr) | i_irq;
      if (i_trap_we) begin
        r_pre_status <= r_status;
        r_status     <= STATUS_TRAP;
        r_epc        <= i_trap_epc;
        r_cause      <= i_trap_cause;
      end else if (i_exrt_we) begin
        r_status <= r_pre_status;
      end else if (i_we) begin
        case (i_wr_addr)
          CR_STATUS:     r_status     <= status_t'(i_wr_data[1:0]);
          CR_PRE_STATUS: r_pre_status <= status_t'(i_wr_data[1:0]);
          CR_EPC:        r_epc        <= i_wr_data[XLEN-1:2];
          CR_EXP_VECTOR: r_exp_vector <= i_wr_data[XLEN-1:2];
          CR_CAUSE:      r_cause      <= i_wr_data[2:0];
          CR_INT_MASK:   r_int_mask   <= i_wr_data[NIRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_addr)
      CR_STATUS:     o_rd_data = XLEN'(r_status);
      CR_PRE_STATUS: o_rd_data = XLEN'(r_pre_status);
      CR_EPC:        o_rd_data = word2byte(r_epc);
      CR_EXP_VECTOR: o_rd_data = word2byte(r_exp_vector);
      CR_CAUSE:      o_rd_data = XLEN'(r_cause);
      CR_INT_MASK:   o_rd_data = XLEN'(r_int_mask);
      CR_IRQ_PEND:   o_rd_data = XLEN'(r_irq_pend);
      default:       o_rd_data = '0;
    endcase
  end

  assign o_status     = r_status;
  assign o_epc        = r_epc;
  assign o_exp_vector = r_exp_vector;
  assign o_irq_pend   = r_irq_pend;
  assign o_int_mask   = r_int_mask;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush priority, trap entry/return and
// the RUN/DRAIN redirect FSM around the control register file.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             ld_hazard,
  input  logic             mem_en,
  input  logic [PCW-1:0]   mem_pc,
  input  ctrl_op_t         mem_ctrl_op,
  input  exp_code_t        mem_exp_code,
  input  creg_addr_t       mem_dst_addr,
  input  logic [XLEN-1:0]  mem_out,
  input  creg_addr_t       creg_rd_addr,
  output logic [XLEN-1:0]  creg_rd_data,
  output logic             exe_mode,
  output pipe_vec_t        stall,
  output pipe_vec_t        flush,
  output logic [PCW-1:0]   new_pc
);

  state_e           r_state;
  state_e           w_state_nxt;
  status_t          w_status;
  logic [PCW-1:0]   w_epc;
  logic [PCW-1:0]   w_exp_vector;
  logic [NIRQ-1:0]  w_irq_pend;
  logic [NIRQ-1:0]  w_int_mask;
  logic             w_busy;
  logic             w_exc;
  logic             w_int_req;
  logic             w_wrcr;
  logic             w_exrt;
  logic             w_redirect;
  logic             w_trap_we;
  logic             w_exrt_we;
  logic             w_cr_we;
  exp_code_t        w_cause;

  assign w_busy = if_busy | mem_busy;
  assign w_exc  = mem_en && (mem_exp_code != EXP_NONE);
  assign w_wrcr = mem_en && (mem_ctrl_op == CTRL_WRCR);
  assign w_exrt = mem_en && (mem_ctrl_op == CTRL_EXRT);

  assign w_int_req = w_status.int_en
                   & (|(w_irq_pend & ~w_int_mask))
                   & mem_en
                   & (r_state == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_busy) begin
      case (r_state)
        S_RUN:   if (w_redirect) w_state_nxt = S_DRAIN;
        S_DRAIN: w_state_nxt = S_RUN;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Trap entry outranks WRCR/EXRT, which are then dropped for re-execution.
  always_comb begin
    stall      = VEC_NONE;
    flush      = VEC_NONE;
    new_pc     = '0;
    w_redirect = 1'b0;
    w_trap_we  = 1'b0;
    w_exrt_we  = 1'b0;
    w_cr_we    = 1'b0;
    w_cause    = EXP_NONE;
    priority case (1'b1)
      reset: ;
      w_busy: stall = VEC_ALL;
      w_exc: begin
        flush      = VEC_ALL;
        new_pc     = w_exp_vector;
        w_redirect = 1'b1;
        w_trap_we  = 1'b1;
        w_cause    = mem_exp_code;
      end
      w_int_req: begin
        flush      = VEC_ALL;
        new_pc     = w_exp_vector;
        w_redirect = 1'b1;
        w_trap_we  = 1'b1;
        w_cause    = EXP_INT;
      end
      w_exrt: begin
        flush      = VEC_ALL;
        new_pc     = w_epc;
        w_redirect = 1'b1;
        w_exrt_we  = 1'b1;
      end
      w_wrcr: begin
        flush      = VEC_ALL;
        new_pc     = mem_pc;
        w_redirect = 1'b1;
        w_cr_we    = 1'b1;
      end
      ld_hazard: begin
        stall = STALL_LOAD;
        flush = FLUSH_BUBL;
      end
      default: ;
    endcase
  end

  pipe_ctrl_creg u_creg (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_irq        (irq),
    .i_we         (w_cr_we),
    .i_wr_addr    (mem_dst_addr),
    .i_wr_data    (mem_out),
    .i_trap_we    (w_trap_we),
    .i_trap_epc   (pc_prev(mem_pc)),
    .i_trap_cause (w_cause),
    .i_exrt_we    (w_exrt_we),
    .i_rd_addr    (creg_rd_addr),
    .o_rd_data    (creg_rd_data),
    .o_status     (w_status),
    .o_epc        (w_epc),
    .o_exp_vector (w_exp_vector),
    .o_irq_pend   (w_irq_pend),
    .o_int_mask   (w_int_mask)
  );

  assign exe_mode = w_status.mode;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: trap, interrupt, EXRT, hazard/busy,
// DRAIN behaviour and asynchronous reset.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        if_busy;
  logic        mem_busy;
  logic        ld_hazard;
  logic        mem_en;
  logic [29:0] mem_pc;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  mem_exp_code;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_out;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic [29:0] new_pc;

  int n_checks = 0;
  int n_err    = 0;

  always #10 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .mem_en       (mem_en),
    .mem_pc       (mem_pc),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_exp_code (mem_exp_code),
    .mem_dst_addr (mem_dst_addr),
    .mem_out      (mem_out),
    .creg_rd_addr (creg_rd_addr),
    .creg_rd_data (creg_rd_data),
    .exe_mode     (exe_mode),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a,
                       input logic [31:0] exp);
    creg_rd_addr = a;
    #1;
    chk(tag, creg_rd_data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en       = 1'b0;
    mem_ctrl_op  = 2'd0;
    mem_exp_code = 3'd0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    mem_en       = 1'b1;
    mem_ctrl_op  = 2'd1;
    mem_dst_addr = a;
    mem_out      = d;
    mem_pc       = 30'h10;
    #1;
    chk("wrcr_flush", 32'(flush), 32'hF);
    chk("wrcr_newpc", 32'(new_pc), 32'h10);
    tick();
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1; irq = '0; if_busy = 0; mem_busy = 0; ld_hazard = 0;
    mem_en = 0; mem_pc = '0; mem_ctrl_op = '0; mem_exp_code = '0;
    mem_dst_addr = '0; mem_out = '0; creg_rd_addr = '0;
    #3;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_newpc", 32'(new_pc), 32'h0);
    chk("rst_mode", 32'(exe_mode), 32'h0);
    rdchk("rst_mask", 5'd5, 32'hFF);
    rdchk("rst_pend", 5'd6, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Trap with vector 0x100
    wrcr(5'd3, 32'h400);
    rdchk("expvec", 5'd3, 32'h400);
    mem_en = 1; mem_exp_code = EXP_TRAP; mem_pc = 30'h21;
    #1;
    chk("trap_flush", 32'(flush), 32'hF);
    chk("trap_newpc", 32'(new_pc), 32'h100);
    tick();
    idle();
    rdchk("trap_epc", 5'd2, 32'h80);
    rdchk("trap_cause", 5'd4, 32'(EXP_TRAP));
    rdchk("trap_status", 5'd0, 32'h0);
    tick();

    // Interrupt on irq[0]
    wrcr(5'd5, 32'hFE);
    wrcr(5'd0, 32'h2);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    rdchk("pend_set", 5'd6, 32'h1);
    mem_en = 1; mem_pc = 30'h50;
    #1;
    chk("int_flush", 32'(flush), 32'hF);
    chk("int_newpc", 32'(new_pc), 32'h100);
    tick();
    idle();
    rdchk("int_cause", 5'd4, 32'h0);
    rdchk("int_epc", 5'd2, 32'h13C);
    rdchk("int_status", 5'd0, 32'h0);
    rdchk("int_pre", 5'd1, 32'h2);
    tick();
    wrcr(5'd6, 32'h1);
    rdchk("pend_clr", 5'd6, 32'h0);

    // EXRT
    wrcr(5'd2, 32'h100);
    wrcr(5'd1, 32'h3);
    mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h70;
    #1;
    chk("exrt_flush", 32'(flush), 32'hF);
    chk("exrt_newpc", 32'(new_pc), 32'h40);
    tick();
    idle();
    #1;
    chk("exrt_mode", 32'(exe_mode), 32'h1);
    rdchk("exrt_status", 5'd0, 32'h3);
    tick();

    // Load hazard under bus wait, then trap under bus wait
    ld_hazard = 1; mem_busy = 1;
    #1;
    chk("busy_stall", 32'(stall), 32'hF);
    chk("busy_flush", 32'(flush), 32'h0);
    tick();
    mem_busy = 0;
    #1;
    chk("ld_stall", 32'(stall), 32'h3);
    chk("ld_flush", 32'(flush), 32'h4);
    tick();
    ld_hazard = 0;
    mem_en = 1; mem_exp_code = EXP_TRAP; if_busy = 1;
    #1;
    chk("ibusy_stall", 32'(stall), 32'hF);
    chk("ibusy_flush", 32'(flush), 32'h0);
    tick();
    idle();
    if_busy = 0;
    rdchk("ibusy_cause", 5'd4, 32'h0);
    rdchk("ibusy_status", 5'd0, 32'h3);

    // WRCR STATUS collides with pending interrupt
    irq = 8'h01;
    tick();
    irq = 8'h00;
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0;
    mem_out = 32'h1; mem_pc = 30'h61;
    #1;
    chk("coll_flush", 32'(flush), 32'hF);
    chk("coll_newpc", 32'(new_pc), 32'h100);
    tick();
    idle();
    rdchk("coll_status", 5'd0, 32'h0);
    rdchk("coll_pre", 5'd1, 32'h3);
    rdchk("coll_epc", 5'd2, 32'h180);
    rdchk("coll_cause", 5'd4, 32'h0);
    tick();

    // Return, then interrupt blocked in DRAIN, taken in RUN with PC wrap
    mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h7;
    #1;
    chk("ret_newpc", 32'(new_pc), 32'h60);
    tick();
    mem_ctrl_op = 2'd0; mem_pc = 30'h0;
    #1;
    chk("drain_flush", 32'(flush), 32'h0);
    chk("drain_stall", 32'(stall), 32'h0);
    tick();
    #1;
    chk("run_int_flush", 32'(flush), 32'hF);
    chk("run_int_newpc", 32'(new_pc), 32'h100);
    tick();
    idle();
    rdchk("wrap_epc", 5'd2, 32'hFFFF_FFFC);
    rdchk("wrap_pre", 5'd1, 32'h3);

    // Exception honoured in DRAIN, then async reset
    mem_en = 1; mem_exp_code = EXP_TRAP; mem_pc = 30'h5; ld_hazard = 1;
    #1;
    chk("dexc_flush", 32'(flush), 32'hF);
    chk("dexc_newpc", 32'(new_pc), 32'h100);
    reset = 1'b1;
    #1;
    chk("arst_flush", 32'(flush), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_newpc", 32'(new_pc), 32'h0);
    chk("arst_mode", 32'(exe_mode), 32'h0);
    rdchk("arst_epc", 5'd2, 32'h0);
    rdchk("arst_mask", 5'd5, 32'hFF);
    rdchk("arst_vec", 5'd3, 32'h0);
    tick();
    reset = 1'b0;
    ld_hazard = 0;
    idle();
    tick();

    // Post-reset interrupt on first eligible cycle
    wrcr(5'd5, 32'hFE);
    wrcr(5'd0, 32'h2);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    mem_en = 1; mem_pc = 30'h99;
    #1;
    chk("pr_flush", 32'(flush), 32'hF);
    chk("pr_newpc", 32'(new_pc), 32'h0);
    tick();
    idle();
    rdchk("pr_epc", 5'd2, 32'h260);
    rdchk("pr_pre", 5'd1, 32'h2);
    rdchk("pr_cause", 5'd4, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
